hash_cmd_arbiter: RTL and testbench

HASH_CMD_ARBITER -- requirements
Module: hash_cmd_arbiter

---
 rtl/hash_cmd_arbiter_pkg.sv | 53 +++++
 rtl/hash_cmd_arbiter_if.sv | 28 ++
 rtl/hash_cmd_arbiter_rr.sv | 28 ++
 rtl/hash_cmd_arbiter.sv | 141 ++++++++++++++
 tb/tb_hash_cmd_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hash_cmd_arbiter_pkg.sv
// Shared types for the hash command arbiter and its requesters.
// Command/return payloads, arbiter states and default sizing.
package HASH_TYPEDEFS_P;

  localparam int HASH_NUM_REQ        = 3;
  localparam int HASH_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    CMD_NOP,
    CMD_FIND,
    CMD_INSERT,
    CMD_DELETE
  } hash_op_t;

  typedef enum logic [1:0] {
    RET_NONE,
    RET_FOUND,
    RET_NOT_FOUND,
    RET_ERROR
  } hash_ret_code_t;

  typedef struct packed {
    hash_op_t    cmd;
    logic [15:0] key;
    logic [31:0] data;
  } hash_cmd_intf_t;

  typedef struct packed {
    hash_ret_code_t hash_ret;
    logic [15:0]    hash_node_addr;
    logic [31:0]    hash_data;
  } hash_ret_intf_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } hash_arb_state_t;

  function automatic int hash_idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic hash_ret_intf_t hash_timeout_ret();
    hash_ret_intf_t r;
    r.hash_ret       = RET_ERROR;
    r.hash_node_addr = '0;
    r.hash_data      = '0;
    return r;
  endfunction

endpackage

// File: rtl/hash_cmd_arbiter_if.sv
// Engine-side command/return bundle of the hash arbiter.
// master = arbiter, slave = hash engine.
interface hash_cmd_arbiter_if;
  import HASH_TYPEDEFS_P::*;

  logic           hash_cmd_valid;
  hash_cmd_intf_t hash_cmd;
  logic           hash_cmd_ready;
  logic           hash_ret_valid;
  hash_ret_intf_t hash_ret;

  modport master (
    output hash_cmd_valid,
    output hash_cmd,
    input  hash_cmd_ready,
    input  hash_ret_valid,
    input  hash_ret
  );

  modport slave (
    input  hash_cmd_valid,
    input  hash_cmd,
    output hash_cmd_ready,
    output hash_ret_valid,
    output hash_ret
  );

endinterface

// File: rtl/hash_cmd_arbiter_rr.sv
// Round-robin pick: first set request above last, wrapping.
// Purely combinational.
module rr_priority_select #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Walk downward so the closest candidate is written last.
  always_comb begin
    cand = '0;
    idx  = last;
    any  = |req;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(last) + i) % N);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/hash_cmd_arbiter.sv
// Shares one hash engine among NUM_REQ requesters, one command
// in flight, round-robin grant and a return timeout.
module hash_cmd_arbiter
  import HASH_TYPEDEFS_P::*;
#(
  parameter int NUM_REQ        = HASH_NUM_REQ,
  parameter int TIMEOUT_CYCLES = HASH_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic          [NUM_REQ-1:0] req_valid,
  input  hash_cmd_intf_t [NUM_REQ-1:0] req_cmd,
  output logic          [NUM_REQ-1:0] req_ready,
  output logic          [NUM_REQ-1:0] rsp_valid,
  output hash_ret_intf_t              rsp,
  hash_cmd_arbiter_if.master          eng,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IW = hash_idx_w(NUM_REQ);
  localparam int CW = hash_idx_w(TIMEOUT_CYCLES);

  localparam logic [CW-1:0]      CNT_MAX  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]      LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  hash_arb_state_t state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  hash_cmd_intf_t  cmd_q, cmd_d;
  logic            cmd_valid_q, cmd_valid_d;
  hash_ret_intf_t  rsp_q, rsp_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            timeout_err_q, timeout_err_d;
  logic            busy_q, busy_d;

  logic [IW-1:0] sel_idx;
  logic          sel_any;

  rr_priority_select #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req  (req_valid),
    .last (last_grant_q),
    .idx  (sel_idx),
    .any  (sel_any)
  );

  // Capture happens at the edge closing the idle cycle.
  assign req_ready = (rst_n && state_q == ARB_IDLE && sel_any)
                   ? (ONE << sel_idx) : '0;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    cmd_valid_d   = cmd_valid_q;
    rsp_d         = rsp_q;
    rsp_valid_d   = '0;
    timeout_err_d = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (sel_any) begin
          grant_d     = sel_idx;
          cmd_d       = req_cmd[sel_idx];
          cmd_valid_d = 1'b1;
          state_d     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (eng.hash_cmd_ready) begin
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        // A return on the last counted cycle beats the timeout.
        if (eng.hash_ret_valid) begin
          rsp_d       = eng.hash_ret;
          rsp_valid_d = ONE << grant_q;
          state_d     = ARB_RESP;
        end else if (cnt_q == CNT_MAX) begin
          rsp_d         = hash_timeout_ret();
          rsp_valid_d   = ONE << grant_q;
          timeout_err_d = 1'b1;
          state_d       = ARB_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ARB_RESP: begin
        last_grant_d = grant_q;
        state_d      = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      last_grant_q  <= LAST_RST;
      cnt_q         <= '0;
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      rsp_q         <= '0;
      rsp_valid_q   <= '0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      rsp_q         <= rsp_d;
      rsp_valid_q   <= rsp_valid_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign eng.hash_cmd_valid = cmd_valid_q;
  assign eng.hash_cmd       = cmd_q;
  assign rsp                = rsp_q;
  assign rsp_valid          = rsp_valid_q;
  assign timeout_err        = timeout_err_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_hash_cmd_arbiter.sv
// Directed bench for hash_cmd_arbiter: transaction table plus
// reset and mid-flight reset sequences.
module tb_hash_cmd_arbiter;
  import HASH_TYPEDEFS_P::*;

  logic clk = 1'b0;
  logic rst_n;
  logic           [2:0] req_valid;
  hash_cmd_intf_t [2:0] req_cmd;
  logic           [2:0] req_ready;
  logic           [2:0] rsp_valid;
  hash_ret_intf_t       rsp;
  logic                 busy;
  logic                 timeout_err;

  hash_cmd_arbiter_if eng_if ();

  hash_cmd_arbiter #(
    .NUM_REQ        (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_cmd     (req_cmd),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp         (rsp),
    .eng         (eng_if),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     req;
    bit             hold;
    bit             stray;
    hash_op_t       op;
    logic [15:0]    key;
    int             rdy;
    int             ret;
    hash_ret_code_t code;
    logic [15:0]    addr;
    logic [31:0]    data;
    int             exp_g;
    bit             exp_to;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic [2:0] req, bit hold, bit stray, hash_op_t op,
    logic [15:0] key, int rdy, int ret, hash_ret_code_t code,
    logic [15:0] addr, logic [31:0] data, int g, bit to);
    vec_t v;
    v.req = req; v.hold = hold; v.stray = stray; v.op = op;
    v.key = key; v.rdy = rdy; v.ret = ret; v.code = code;
    v.addr = addr; v.data = data; v.exp_g = g; v.exp_to = to;
    return v;
  endfunction

  function automatic hash_cmd_intf_t cmd_of(vec_t v, int i);
    hash_cmd_intf_t c;
    c.cmd  = v.op;
    c.key  = v.key + 16'(i);
    c.data = {16'hC0DE, 16'(i)};
    return c;
  endfunction

  task automatic drive_cmds(input vec_t v, input bit scramble);
    hash_cmd_intf_t t;
    for (int i = 0; i < 3; i++) begin
      t = cmd_of(v, i);
      req_cmd[i] = scramble ? hash_cmd_intf_t'(~t) : t;
    end
  endtask

  // One transaction; cycle 0 is the grant cycle.
  task automatic run_txn(input vec_t v);
    int w, ret_c, lat;
    bit early;
    hash_cmd_intf_t exp_c;
    hash_ret_intf_t exp_r, r;
    w     = v.rdy + 2;
    ret_c = v.exp_to ? -1 : w + v.ret;
    lat   = v.exp_to ? w + 16 : ret_c + 1;
    exp_c = cmd_of(v, v.exp_g);
    if (v.exp_to) begin
      exp_r.hash_ret = RET_ERROR;
      exp_r.hash_node_addr = '0;
      exp_r.hash_data = '0;
    end else begin
      exp_r.hash_ret = v.code;
      exp_r.hash_node_addr = v.addr;
      exp_r.hash_data = v.data;
    end
    early = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
      end else if (c <= v.rdy + 1) begin
        chk("cmd_valid_held", 64'(eng_if.hash_cmd_valid), 64'(1));
        chk("cmd_stable", 64'(eng_if.hash_cmd), 64'(exp_c));
      end else if (c == w) begin
        chk("cmd_valid_drop", 64'(eng_if.hash_cmd_valid), 64'(0));
      end
      if (c > 0 && c < lat && (rsp_valid != 0 || timeout_err))
        early = 1'b1;
      if (c == lat) begin
        chk("rsp_valid", 64'(rsp_valid), 64'(3'b001 << v.exp_g));
        chk("rsp", 64'(rsp), 64'(exp_r));
        chk("timeout_err", 64'(timeout_err), 64'(v.exp_to));
        chk("resp_busy", 64'(busy), 64'(1));
        chk("early_rsp", 64'(early), 64'(0));
      end
      drive_cmds(v, c != 0);
      req_valid = (c == 0 || v.hold) ? v.req : 3'b000;
      eng_if.hash_cmd_ready = (c == v.rdy + 1);
      eng_if.hash_ret_valid = (c == ret_c) || (v.stray && c == 1);
      if (c == ret_c) begin
        r.hash_ret = v.code;
        r.hash_node_addr = v.addr;
        r.hash_data = v.data;
      end else begin
        r.hash_ret = RET_FOUND;
        r.hash_node_addr = 16'hBAD0;
        r.hash_data = 32'hBAD0_BAD0;
      end
      eng_if.hash_ret = r;
      if (c == 0) begin
        #1;
        chk("req_ready", 64'(req_ready), 64'(3'b001 << v.exp_g));
      end
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_cmd_valid", 64'(eng_if.hash_cmd_valid), 64'(0));
    chk("rst_timeout_err", 64'(timeout_err), 64'(0));
    chk("rst_rsp", 64'(rsp), 64'(0));
    chk("rst_hash_cmd", 64'(eng_if.hash_cmd), 64'(0));
    req_valid = 3'b111;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
  endtask

  vec_t tbl[12];
  vec_t post;
  vec_t mid;
  bit   stray_seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(3'b111, 1, 0, CMD_FIND,   16'h0100, 0,  0, RET_FOUND,     16'h0001, 32'h1000_0001, 0, 0);
    tbl[1]  = mk(3'b111, 1, 0, CMD_INSERT, 16'h0200, 0,  1, RET_FOUND,     16'h0002, 32'h1000_0002, 1, 0);
    tbl[2]  = mk(3'b111, 1, 0, CMD_DELETE, 16'h0300, 0,  0, RET_NOT_FOUND, 16'h0003, 32'h1000_0003, 2, 0);
    tbl[3]  = mk(3'b111, 1, 0, CMD_FIND,   16'h0400, 1,  0, RET_FOUND,     16'h0004, 32'h1000_0004, 0, 0);
    tbl[4]  = mk(3'b111, 1, 0, CMD_FIND,   16'h0500, 0,  3, RET_FOUND,     16'h0005, 32'h1000_0005, 1, 0);
    tbl[5]  = mk(3'b111, 0, 0, CMD_FIND,   16'h0600, 0,  0, RET_FOUND,     16'h0006, 32'h1000_0006, 2, 0);
    tbl[6]  = mk(3'b001, 0, 0, CMD_FIND,   16'h0012, 0,  0, RET_FOUND,     16'h0012, 32'hDEAD_BEEF, 0, 0);
    tbl[7]  = mk(3'b010, 0, 1, CMD_INSERT, 16'h0700, 5,  2, RET_FOUND,     16'h0070, 32'h0000_7777, 1, 0);
    tbl[8]  = mk(3'b100, 0, 0, CMD_FIND,   16'h0800, 0, -1, RET_FOUND,     16'hFFFF, 32'hFFFF_FFFF, 2, 1);
    tbl[9]  = mk(3'b001, 0, 0, CMD_FIND,   16'h0900, 0, 15, RET_FOUND,     16'h0090, 32'h9999_0000, 0, 0);
    tbl[10] = mk(3'b101, 0, 0, CMD_DELETE, 16'h0A00, 0, 14, RET_NOT_FOUND, 16'h00A0, 32'hAAAA_0000, 2, 0);
    tbl[11] = mk(3'b011, 0, 1, CMD_FIND,   16'h0B00, 2,  0, RET_FOUND,     16'h00B0, 32'hBBBB_0000, 0, 0);
    mid     = mk(3'b010, 0, 0, CMD_FIND,   16'h0D00, 0,  0, RET_FOUND,     16'h00D0, 32'hDDDD_0000, 1, 0);
    post    = mk(3'b111, 0, 0, CMD_FIND,   16'h0C00, 0,  0, RET_FOUND,     16'h00C0, 32'hCCCC_0000, 0, 0);

    rst_n = 1'b0;
    req_valid = 3'b111;
    drive_cmds(tbl[0], 1'b0);
    eng_if.hash_cmd_ready = 1'b0;
    eng_if.hash_ret_valid = 1'b0;
    eng_if.hash_ret = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    req_valid = 3'b000;

    for (int k = 0; k < 12; k++) begin
      run_txn(tbl[k]);
    end

    // Reset while waiting for the engine return.
    @(negedge clk);
    drive_cmds(mid, 1'b0);
    req_valid = mid.req;
    #1;
    chk("mid_req_ready", 64'(req_ready), 64'(3'b010));
    @(negedge clk);
    req_valid = 3'b000;
    drive_cmds(mid, 1'b1);
    eng_if.hash_cmd_ready = 1'b1;
    @(negedge clk);
    eng_if.hash_cmd_ready = 1'b0;
    chk("mid_wait_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    req_valid = 3'b000;
    rst_n = 1'b1;
    stray_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid != 0 || timeout_err || busy)
        stray_seen = 1'b1;
      eng_if.hash_ret_valid = (c == 2);
    end
    eng_if.hash_ret_valid = 1'b0;
    chk("abandoned_no_rsp", 64'(stray_seen), 64'(0));
    run_txn(post);

    @(negedge clk);
    chk("final_busy", 64'(busy), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
